// File: rtl/ysyx_22041211_ifu.sv
// ysyx_22041211_ifu -- instruction fetch unit.
// Owns the PC and issues one instruction-memory fetch at a time (request,
// wait for response, present to IDU). Accepts EXU redirects in any state.
// Optional feature: define YSYX_22041211_IFU_PERF_EN to enable the
// retired-fetch counter. Otherwise fetch_cnt is tied to zero.
module ysyx_22041211_ifu #(
  parameter int unsigned          DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [DATA_LEN-1:0] imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [DATA_LEN-1:0] imem_resp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [DATA_LEN-1:0] inst,
  output logic [DATA_LEN-1:0] pc,
  input  logic                redirect_valid,
  input  logic [DATA_LEN-1:0] redirect_pc,
  output logic [31:0]         fetch_cnt
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;

  state_t              state;
  logic                pend;
  logic [DATA_LEN-1:0] pend_pc;
  logic [DATA_LEN-1:0] tgt_pc;
  logic                req_fire;
  logic                inst_fire;

  // Redirect target is always word aligned; low bits from EXU are dropped.
  assign tgt_pc = {redirect_pc[DATA_LEN-1:2], 2'b00};

  // Handshake qualifiers are decoded from state and gated by reset so that
  // nothing is presented to memory or IDU while reset is asserted.
  assign imem_req_valid = rst_n && (state == S_REQ);
  assign inst_valid     = rst_n && (state == S_OUT);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign inst_fire      = inst_valid && inst_ready;

  // Fetch FSM: one request in flight; a redirect that arrives after the
  // request was accepted is remembered in pend/pend_pc and the stale
  // response is thrown away when it comes back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      inst    <= '0;
      pend    <= 1'b0;
      pend_pc <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) begin
            state <= S_WAIT;
            if (redirect_valid) begin
              pend    <= 1'b1;
              pend_pc <= tgt_pc;
            end
          end else if (redirect_valid) begin
            // Request not yet accepted: retarget in place.
            pc <= tgt_pc;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (redirect_valid) begin
              pc    <= tgt_pc;
              pend  <= 1'b0;
              state <= S_REQ;
            end else if (pend) begin
              pc    <= pend_pc;
              pend  <= 1'b0;
              state <= S_REQ;
            end else begin
              inst  <= imem_resp_data;
              state <= S_OUT;
            end
          end else if (redirect_valid) begin
            // Later redirects overwrite earlier pending targets.
            pend    <= 1'b1;
            pend_pc <= tgt_pc;
          end
        end
        S_OUT: begin
          // A redirect wins whether or not IDU took the instruction.
          if (redirect_valid) begin
            pc    <= tgt_pc;
            state <= S_REQ;
          end else if (inst_ready) begin
            pc    <= pc + DATA_LEN'(4);
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef YSYX_22041211_IFU_PERF_EN
  // Count instructions actually accepted by IDU; squashes never handshake.
  always_ff @(posedge clk) begin
    if (!rst_n)         fetch_cnt <= '0;
    else if (inst_fire) fetch_cnt <= fetch_cnt + 32'd1;
  end
`else
  assign fetch_cnt = 32'h0;
  logic unused_ok;
  assign unused_ok = inst_fire;
`endif

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Directed bench for ysyx_22041211_ifu: reset, basic fetch, IDU stall,
// redirects in each state, PC wrap, mid-flight reset and fetch counter.
module tb_ysyx_22041211_ifu;

`ifdef YSYX_22041211_IFU_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_cnt;

  int tests = 0;
  int fails = 0;

  ysyx_22041211_ifu dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
    return PERF ? 32'(n) : 32'h0;
  endfunction

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = '0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0);
    chk("rst_cnt", fetch_cnt, 32'h0);

    // 1: basic fetch
    rst_n = 1'b1; imem_req_ready = 1'b1; #1;
    chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_addr", imem_req_addr, 32'h8000_0000);
    tick();
    chk("t1_wait_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t1_wait_inst_valid", 32'(inst_valid), 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093;
    tick();
    imem_resp_valid = 1'b0;
    chk("t1_inst_valid", 32'(inst_valid), 32'd1);
    chk("t1_inst", inst, 32'h0010_0093);
    chk("t1_pc", pc, 32'h8000_0000);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t1_next_addr", imem_req_addr, 32'h8000_0004);
    chk("t1_next_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_cnt", fetch_cnt, cnt_exp(1));

    // 2: IDU stall for 5 cycles; stray resp_valid must be ignored
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
    tick();
    imem_resp_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 32'(inst_valid), 32'd1);
      chk("t2_hold_inst", inst, 32'h0000_0013);
      chk("t2_hold_pc", pc, 32'h8000_0004);
      chk("t2_no_req", 32'(imem_req_valid), 32'd0);
    end
    imem_resp_valid = 1'b0;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t2_next_addr", imem_req_addr, 32'h8000_0008);
    chk("t2_cnt", fetch_cnt, cnt_exp(2));

    // 3: redirect while waiting -> response discarded
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    chk("t3_still_wait", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0BAD;
    tick();
    imem_resp_valid = 1'b0;
    chk("t3_no_inst", 32'(inst_valid), 32'd0);
    chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t3_addr", imem_req_addr, 32'h8000_0100);

    // 4: req_ready low 3 cycles, redirect in cycle 2
    imem_req_ready = 1'b0;
    tick();
    chk("t4_c1_valid", 32'(imem_req_valid), 32'd1);
    chk("t4_c1_addr", imem_req_addr, 32'h8000_0100);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
    tick();
    redirect_valid = 1'b0;
    chk("t4_c2_valid", 32'(imem_req_valid), 32'd1);
    chk("t4_c2_addr", imem_req_addr, 32'h8000_0040);
    tick();
    chk("t4_c3_valid", 32'(imem_req_valid), 32'd1);
    chk("t4_c3_addr", imem_req_addr, 32'h8000_0040);
    imem_req_ready = 1'b1;
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0093;
    tick();
    imem_resp_valid = 1'b0;
    chk("t4_inst_valid", 32'(inst_valid), 32'd1);
    chk("t4_pc", pc, 32'h8000_0040);

    // 5: squash via redirect to top of memory, then wrap
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    chk("t5_squash", 32'(inst_valid), 32'd0);
    chk("t5_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("t5_cnt", fetch_cnt, cnt_exp(2));
    imem_req_ready = 1'b1;
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
    tick();
    imem_resp_valid = 1'b0;
    chk("t5_pc", pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t5_wrap_addr", imem_req_addr, 32'h0000_0000);
    chk("t5_cnt2", fetch_cnt, cnt_exp(3));

    // 6: reset while waiting, response arrives during reset
    tick();
    rst_n = 1'b0; imem_resp_valid = 1'b1;
    tick();
    chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t6_inst_valid", 32'(inst_valid), 32'd0);
    chk("t6_pc", pc, 32'h8000_0000);
    chk("t6_cnt", fetch_cnt, 32'h0);
    rst_n = 1'b1; imem_resp_valid = 1'b0; #1;
    chk("t6_rel_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t6_rel_addr", imem_req_addr, 32'h8000_0000);

    // ten back-to-back fetches for the counter
    for (int i = 0; i < 10; i++) begin
      tick();
      imem_resp_valid = 1'b1; imem_resp_data = 32'(i);
      tick();
      imem_resp_valid = 1'b0; inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
    end
    chk("t6_cnt10", fetch_cnt, cnt_exp(10));
    chk("t6_pc10", pc, 32'h8000_0028);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
